param_packet_transmitter: RTL and testbench

Parametrised packet framer sitting between the command/response logic and the byte-serial transmit interface (UART-style byte transmitter with start/ready handshake). On a start edge it snapshots a command byte, a data buffer and a per-packet data length, then streams optional SOF, command, optional length byte, data bytes and an inline CRC-8 to the byte interface. The per-packet length comes from a port, and the CRC is computed byte-serially, so no per-command table or separate CRC engine is needed.

---
 rtl/param_packet_transmitter.sv | 217 +++++++++++++++++++++
 tb/tb_param_packet_transmitter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_packet_transmitter.sv
// Packet framer: snapshots cmd/data/length on a start edge and streams
// [SOF] CMD [LEN] DATA... [CRC-8] through a start/ready byte interface.
module param_packet_transmitter #(
  parameter int         BUFFER_LENGTH = 24,
  parameter int         COUNTER_SIZE  = 8,
  parameter bit         USE_SOF       = 1'b0,
  parameter logic [7:0] SOF_BYTE      = 8'hA5,
  parameter bit         USE_LEN       = 1'b0,
  parameter bit         USE_CRC       = 1'b1,
  parameter logic [7:0] CRC_POLY      = 8'h07,
  parameter logic [7:0] CRC_INIT      = 8'h00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 out_cmd,
  input  logic [8*BUFFER_LENGTH-1:0] out_data,
  input  logic [COUNTER_SIZE-1:0]    data_size,
  input  logic                       start_packet_tran,
  input  logic                       flush,
  input  logic                       tran_interface_ready,
  output logic                       tran_interface_start,
  output logic [7:0]                 tran_interface_out_byte,
  output logic                       busy,
  output logic                       tran_complete,
  output logic                       size_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACCEPT, WAIT_DONE} state_t;
  typedef enum logic [2:0] {F_SOF, F_CMD, F_LEN, F_DATA, F_CRC} field_t;

  localparam logic [COUNTER_SIZE-1:0] BUF_LEN_C = COUNTER_SIZE'(BUFFER_LENGTH);

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

  state_t                    state_q, state_d;
  field_t                    field_q, field_d, field_adv;
  logic [COUNTER_SIZE-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [7:0]                crc_q, crc_d;
  logic                      start_q, start_d;
  logic [7:0]                byte_q, byte_d;
  logic                      busy_q, busy_d;
  logic                      cmplt_q, cmplt_d;
  logic                      serr_q, serr_d;
  logic                      start_prev, flush_prev, ready_prev;
  logic                      cap_en, last_field;
  logic [7:0]                cmd_r;
  logic [8*BUFFER_LENGTH-1:0] data_r;
  logic [COUNTER_SIZE-1:0]   size_r;
  logic [7:0]                data_byte, field_byte;
  logic                      start_edge, flush_edge, ready_rise;

  assign start_edge = start_packet_tran & ~start_prev;
  assign flush_edge = flush & ~flush_prev;
  assign ready_rise = tran_interface_ready & ~ready_prev;
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    data_byte = 8'h00;
    for (int i = 0; i < BUFFER_LENGTH; i++)
      if (cnt_q == COUNTER_SIZE'(i)) data_byte = data_r[8*i +: 8];
  end

  always_comb begin
    case (field_q)
      F_SOF:   field_byte = SOF_BYTE;
      F_CMD:   field_byte = cmd_r;
      F_LEN:   field_byte = 8'(size_r);
      F_DATA:  field_byte = data_byte;
      default: field_byte = crc_q;
    endcase
  end

  // Field sequencing: which field follows the one just completed
  always_comb begin
    field_adv  = F_CRC;
    last_field = 1'b0;
    case (field_q)
      F_SOF: field_adv = F_CMD;
      F_CMD: begin
        if (USE_LEN)               field_adv = F_LEN;
        else if (size_r != '0)     field_adv = F_DATA;
        else if (USE_CRC)          field_adv = F_CRC;
        else                       last_field = 1'b1;
      end
      F_LEN: begin
        if (size_r != '0)          field_adv = F_DATA;
        else if (USE_CRC)          field_adv = F_CRC;
        else                       last_field = 1'b1;
      end
      F_DATA: begin
        if (cnt_inc < size_r)      field_adv = F_DATA;
        else if (USE_CRC)          field_adv = F_CRC;
        else                       last_field = 1'b1;
      end
      default: last_field = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    start_d = start_q;
    byte_d  = byte_q;
    busy_d  = busy_q;
    cmplt_d = cmplt_q;
    serr_d  = serr_q;
    cap_en  = 1'b0;
    if (flush_edge) begin
      state_d = IDLE;
      start_d = 1'b0;
      busy_d  = 1'b0;
      cmplt_d = 1'b1;
      cnt_d   = '0;
      crc_d   = CRC_INIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            if (data_size > BUF_LEN_C) begin
              serr_d  = 1'b1;
              cmplt_d = 1'b1;
            end else begin
              cap_en  = 1'b1;
              serr_d  = 1'b0;
              cmplt_d = 1'b0;
              busy_d  = 1'b1;
              crc_d   = CRC_INIT;
              cnt_d   = '0;
              field_d = USE_SOF ? F_SOF : F_CMD;
              state_d = ISSUE;
            end
          end
        end
        ISSUE: begin
          byte_d  = field_byte;
          start_d = 1'b1;
          if (field_q == F_CMD || field_q == F_LEN || field_q == F_DATA)
            crc_d = crc8_step(crc_q, field_byte);
          state_d = ACCEPT;
        end
        ACCEPT: begin
          if (!tran_interface_ready) begin
            start_d = 1'b0;
            state_d = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (ready_rise) begin
            if (last_field) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              cmplt_d = 1'b1;
            end else begin
              if (field_q == F_DATA) cnt_d = cnt_inc;
              field_d = field_adv;
              state_d = ISSUE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      field_q    <= F_CMD;
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      start_q    <= 1'b0;
      byte_q     <= 8'h00;
      busy_q     <= 1'b0;
      cmplt_q    <= 1'b0;
      serr_q     <= 1'b0;
      start_prev <= 1'b0;
      flush_prev <= 1'b0;
      ready_prev <= 1'b1;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      start_q    <= start_d;
      byte_q     <= byte_d;
      busy_q     <= busy_d;
      cmplt_q    <= cmplt_d;
      serr_q     <= serr_d;
      start_prev <= start_packet_tran;
      flush_prev <= flush;
      ready_prev <= tran_interface_ready;
    end
  end

  // Packet snapshot: later input changes must not leak into a packet in flight
  always_ff @(posedge clk) begin
    if (cap_en) begin
      cmd_r  <= out_cmd;
      data_r <= out_data;
      size_r <= data_size;
    end
  end

  assign tran_interface_start    = start_q;
  assign tran_interface_out_byte = byte_q;
  assign busy                    = busy_q;
  assign tran_complete           = cmplt_q;
  assign size_error              = serr_q;

endmodule

// File: tb/tb_param_packet_transmitter.sv
// Bench for param_packet_transmitter: two instances (default framing and
// SOF+LEN framing) share stimulus, each with its own byte-interface model.
module tb_param_packet_transmitter;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd;
  logic [191:0] out_data;
  logic [7:0]  dsize;
  logic        start, flush;
  logic        rdy0, rdy1;
  logic        st0, st1, busy0, busy1, cmp0, cmp1, se0, se1;
  logic [7:0]  ob0, ob1;

  logic [7:0]  dat [24];
  bq_t         q0, q1;
  bit          en0 = 1'b1, en1 = 1'b1;
  int          extra_hold = 0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  param_packet_transmitter dut0 (
    .clk(clk), .reset(rst_n), .out_cmd(cmd), .out_data(out_data), .data_size(dsize),
    .start_packet_tran(start), .flush(flush), .tran_interface_ready(rdy0),
    .tran_interface_start(st0), .tran_interface_out_byte(ob0), .busy(busy0),
    .tran_complete(cmp0), .size_error(se0));

  param_packet_transmitter #(.USE_SOF(1'b1), .USE_LEN(1'b1)) dut1 (
    .clk(clk), .reset(rst_n), .out_cmd(cmd), .out_data(out_data), .data_size(dsize),
    .start_packet_tran(start), .flush(flush), .tran_interface_ready(rdy1),
    .tran_interface_start(st1), .tran_interface_out_byte(ob1), .busy(busy1),
    .tran_complete(cmp1), .size_error(se1));

  // Byte interface models: accept on start, stay busy a few cycles, then ready
  initial begin
    rdy0 = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && en0 && st0 && rdy0) begin
        q0.push_back(ob0);
        rdy0 = 1'b0;
        repeat ($urandom_range(1, 4) + extra_hold) @(negedge clk);
        rdy0 = 1'b1;
      end
    end
  end

  initial begin
    rdy1 = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && en1 && st1 && rdy1) begin
        q1.push_back(ob1);
        rdy1 = 1'b0;
        repeat ($urandom_range(1, 4) + extra_hold) @(negedge clk);
        rdy1 = 1'b1;
      end
    end
  end

  // CRC as the remainder of (message * x^8) divided by x^8 + x^2 + x + 1
  function automatic logic [7:0] crc_model(input bq_t msg);
    logic [8:0] r;
    logic       b;
    r = 9'h000;
    for (int i = 0; i <= msg.size(); i++)
      for (int k = 7; k >= 0; k--) begin
        b = (i < msg.size()) ? msg[i][k] : 1'b0;
        r = {r[7:0], b};
        if (r[8]) r = r ^ 9'h107;
      end
    return r[7:0];
  endfunction

  function automatic bq_t packet_model(input bit sof, input bit len, input logic [7:0] c,
                                       input int sz, input logic [7:0] d [24]);
    bq_t body, p;
    body.push_back(c);
    if (len) body.push_back(8'(sz));
    for (int i = 0; i < sz; i++) body.push_back(d[i]);
    if (sof) p.push_back(8'hA5);
    foreach (body[i]) p.push_back(body[i]);
    p.push_back(crc_model(body));
    return p;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 24; i++) out_data[8*i +: 8] = dat[i];
  endtask

  task automatic run_packet(input logic [7:0] c, input int sz, input bit scramble);
    bq_t e0, e1;
    int  cyc, bad0, bad1;
    e0 = packet_model(1'b0, 1'b0, c, sz, dat);
    e1 = packet_model(1'b1, 1'b1, c, sz, dat);
    q0.delete(); q1.delete();
    @(negedge clk);
    cmd = c; dsize = 8'(sz); drive_data(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1 || cmp0 !== 1'b0 || cmp1 !== 1'b0 || se0 !== 1'b0 || se1 !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_begin busy=%b/%b cmp=%b/%b serr=%b/%b required busy=1 cmp=0 serr=0", busy0, busy1, cmp0, cmp1, se0, se1);
    end
    if (scramble) begin
      for (int i = 0; i < 24; i++) dat[i] = 8'($urandom);
      drive_data(); cmd = 8'($urandom); dsize = 8'($urandom_range(0, 24));
    end
    @(negedge clk);
    n_tests++;
    if (st0 !== 1'b1 || ob0 !== e0[0] || st1 !== 1'b1 || ob1 !== e1[0]) begin
      n_fail++;
      $display("FAIL first_byte start=%b/%b byte=%02h/%02h required 1/1 %02h/%02h", st0, st1, ob0, ob1, e0[0], e1[0]);
    end
    cyc = 0;
    while ((busy0 || busy1) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 5 && busy0 && busy1) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    n_tests++;
    if (cyc >= 4000) begin
      n_fail++;
      $display("FAIL pkt_timeout busy=%b/%b required 0/0 within 4000 cycles", busy0, busy1);
    end
    n_tests++;
    if (cmp0 !== 1'b1 || cmp1 !== 1'b1 || se0 !== 1'b0 || se1 !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_end cmp=%b/%b serr=%b/%b required cmp=1 serr=0", cmp0, cmp1, se0, se1);
    end
    n_tests++;
    if (q0.size() != e0.size() || q1.size() != e1.size()) begin
      n_fail++;
      $display("FAIL pkt_len got %0d/%0d bytes required %0d/%0d", q0.size(), q1.size(), e0.size(), e1.size());
    end
    bad0 = -1; bad1 = -1;
    for (int i = e0.size() - 1; i >= 0; i--) if (i < q0.size() && q0[i] !== e0[i]) bad0 = i;
    for (int i = e1.size() - 1; i >= 0; i--) if (i < q1.size() && q1[i] !== e1[i]) bad1 = i;
    n_tests++;
    if (bad0 >= 0) begin
      n_fail++;
      $display("FAIL pkt_bytes dut0 idx %0d got %02h required %02h", bad0, q0[bad0], e0[bad0]);
    end
    n_tests++;
    if (bad1 >= 0) begin
      n_fail++;
      $display("FAIL pkt_bytes dut1 idx %0d got %02h required %02h", bad1, q1[bad1], e1[bad1]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; cmd = 8'h00; dsize = 8'h00;
    for (int i = 0; i < 24; i++) dat[i] = 8'h00;
    drive_data();
    repeat (3) @(negedge clk);
    n_tests++;
    if (st0 !== 1'b0 || ob0 !== 8'h00 || busy0 !== 1'b0 || cmp0 !== 1'b0 || se0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut0 start=%b byte=%02h busy=%b cmp=%b serr=%b required all 0", st0, ob0, busy0, cmp0, se0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (st1 !== 1'b0 || ob1 !== 8'h00 || busy1 !== 1'b0 || cmp1 !== 1'b0 || se1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut1 start=%b byte=%02h busy=%b cmp=%b serr=%b required all 0", st1, ob1, busy1, cmp1, se1);
    end
  endtask

  task automatic test_basic();
    run_packet(8'h01, 0, 1'b0);
    n_tests++;
    if (q0.size() != 2 || q0[0] !== 8'h01 || q0[1] !== 8'h07) begin
      n_fail++;
      $display("FAIL basic_cmd01 got %0d bytes first %02h required 01 07", q0.size(), q0.size() > 0 ? q0[0] : 8'hxx);
    end
  endtask

  task automatic test_ascii();
    for (int i = 0; i < 24; i++) dat[i] = (i < 8) ? 8'(8'h32 + i) : 8'(i);
    run_packet(8'h31, 8, 1'b0);
    n_tests++;
    if (q0.size() != 10 || q0[9] !== 8'hF4) begin
      n_fail++;
      $display("FAIL ascii_crc got %0d bytes last %02h required 10 bytes last f4", q0.size(), q0.size() > 0 ? q0[q0.size()-1] : 8'hxx);
    end
  endtask

  task automatic test_sof_len();
    bq_t body;
    logic [7:0] crc;
    body = '{8'hD0, 8'h01, 8'h5A};
    crc = crc_model(body);
    dat[0] = 8'h5A;
    run_packet(8'hD0, 1, 1'b1);
    n_tests++;
    if (q1.size() != 5 || q1[0] !== 8'hA5 || q1[1] !== 8'hD0 || q1[2] !== 8'h01 || q1[3] !== 8'h5A || q1[4] !== crc) begin
      n_fail++;
      $display("FAIL sof_len got %0d bytes required a5 d0 01 5a %02h", q1.size(), crc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 24; i++) dat[i] = 8'($urandom);
      run_packet(8'($urandom), $urandom_range(0, 24), 1'($urandom));
    end
  endtask

  task automatic test_size_error();
    q0.delete(); q1.delete();
    @(negedge clk);
    cmd = 8'h42; dsize = 8'd25; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (se0 !== 1'b1 || se1 !== 1'b1 || cmp0 !== 1'b1 || cmp1 !== 1'b1 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL size_err serr=%b/%b cmp=%b/%b busy=%b/%b required serr=1 cmp=1 busy=0", se0, se1, cmp0, cmp1, busy0, busy1);
    end
    repeat (12) @(negedge clk);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0 || se0 !== 1'b1) begin
      n_fail++;
      $display("FAIL size_err_nosend got %0d/%0d bytes serr=%b required 0/0 serr=1", q0.size(), q1.size(), se0);
    end
    for (int i = 0; i < 24; i++) dat[i] = 8'($urandom);
    run_packet(8'h77, 24, 1'b0);
  endtask

  task automatic test_flush();
    int cyc, n1;
    for (int i = 0; i < 24; i++) dat[i] = 8'($urandom);
    q0.delete(); q1.delete();
    extra_hold = 8;
    @(negedge clk);
    cmd = 8'h9C; dsize = 8'd10; drive_data(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (q0.size() < 4 && cyc < 500) begin
      @(negedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (cyc >= 500) begin
      n_fail++;
      $display("FAIL flush_reach got %0d bytes required 4 within 500 cycles", q0.size());
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n1 = q1.size();
    n_tests++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || cmp0 !== 1'b1 || cmp1 !== 1'b1 || st0 !== 1'b0 || st1 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_abort busy=%b/%b cmp=%b/%b start=%b/%b required busy=0 cmp=1 start=0", busy0, busy1, cmp0, cmp1, st0, st1);
    end
    repeat (30) @(negedge clk);
    extra_hold = 0;
    n_tests++;
    if (q0.size() != 4 || q1.size() != n1) begin
      n_fail++;
      $display("FAIL flush_nomore got %0d/%0d bytes required 4/%0d", q0.size(), q1.size(), n1);
    end
    for (int i = 0; i < 24; i++) dat[i] = 8'($urandom);
    run_packet(8'($urandom), 5, 1'b0);
  endtask

  task automatic test_start_flush_idle();
    q0.delete(); q1.delete();
    @(negedge clk);
    cmd = 8'h11; dsize = 8'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0 || busy0 !== 1'b0 || busy1 !== 1'b0 || cmp0 !== 1'b1 || cmp1 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_flush got %0d/%0d bytes busy=%b/%b cmp=%b/%b required 0/0 busy=0 cmp=1", q0.size(), q1.size(), busy0, busy1, cmp0, cmp1);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    en0 = 1'b0; en1 = 1'b0;
    @(negedge clk);
    cmd = 8'h5E; dsize = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(st0 && st1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (st0 !== 1'b1 || st1 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_setup start=%b/%b required 1/1", st0, st1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (st0 !== 1'b0 || st1 !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0 || ob0 !== 8'h00 || ob1 !== 8'h00) begin
      n_fail++;
      $display("FAIL areset start=%b/%b busy=%b/%b byte=%02h/%02h required all 0", st0, st1, busy0, busy1, ob0, ob1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en0 = 1'b1; en1 = 1'b1;
    for (int i = 0; i < 24; i++) dat[i] = 8'($urandom);
    run_packet(8'($urandom), $urandom_range(0, 24), 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_ascii();
    test_sof_len();
    test_random();
    test_size_error();
    test_flush();
    test_start_flush_idle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
